// File: rtl/mac_params.sv
// mac_params: parameters shared by the MAC TX/RX datapath.
//   N_SYMBOLS   : lanes per AXI-Stream beat
//   W_SYMBOL    : bits per lane
//   axis_beat_t : one AXI-Stream beat (data, keep, last), carried as a single
//                 packed word through register slices
//   arb_state_e : frame arbiter FSM states
package mac_params;

  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;
  localparam int W_DATA    = N_SYMBOLS * W_SYMBOL;

  typedef struct packed {
    logic [W_DATA-1:0]    data;
    logic [N_SYMBOLS-1:0] keep;
    logic                 last;
  } axis_beat_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry (main + skid) register slice for a valid/ready
// stream of any packed beat type. Full throughput, registered out_valid and
// out_beat, and in_ready is a flop (skid entry empty) so there is no
// combinational path from out_ready back to in_ready.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_beat payload
//   out_valid/out_ready   : downstream handshake, out_beat payload
module axis_skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat
);

  logic main_valid_reg;
  logic skid_valid_reg;
  T     main_reg;
  T     skid_reg;

  logic in_fire;
  logic main_load;

  assign in_ready  = ~skid_valid_reg;
  assign in_fire   = in_valid & ~skid_valid_reg;
  // The main entry may take new data when it is empty or being drained.
  assign main_load = out_ready | ~main_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (main_load) begin
      // The skid entry is older than anything on the input, so it drains
      // first; while it is full in_ready is low and no new beat arrives.
      main_valid_reg <= skid_valid_reg | in_fire;
      if (skid_valid_reg) begin
        main_reg <= skid_reg;
      end else if (in_fire) begin
        main_reg <= in_beat;
      end
      skid_valid_reg <= 1'b0;
    end else if (in_fire) begin
      // Main is stalled: park the accepted beat in the skid entry.
      skid_valid_reg <= 1'b1;
      skid_reg       <= in_beat;
    end
  end

  assign out_valid = main_valid_reg;
  assign out_beat  = main_reg;

endmodule

// File: rtl/tx_axis_frame_arbiter.sv
// tx_axis_frame_arbiter: shares the MAC TX AXI-Stream input between N_PORTS
// frame sources. Whole frames are granted round-robin among enabled,
// requesting ports; the output is registered through axis_skid_buffer.
// Ports:
//   i_tx_clk, i_tx_reset_n : TX clock, asynchronous active-low reset
//   i_port_en              : per-port enable, looked at only when arbitrating
//   s_axis_*               : per-port AXI-Stream slaves (tready one-hot or 0)
//   m_axis_*               : AXI-Stream master towards the MAC
//   o_grant                : one-hot current owner, zero when idle
//   o_busy                 : a frame is currently granted
//   o_frame_cnt            : per-port count of forwarded frames (wraps)
module tx_axis_frame_arbiter
  import mac_params::*;
#(
  parameter int N_PORTS = 4,
  parameter int W_FCNT  = 16
) (
  input  logic                                     i_tx_clk,
  input  logic                                     i_tx_reset_n,
  input  logic [N_PORTS-1:0]                       i_port_en,
  input  logic [N_PORTS-1:0]                       s_axis_tvalid,
  input  logic [N_PORTS-1:0][N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0][N_SYMBOLS-1:0]        s_axis_tkeep,
  input  logic [N_PORTS-1:0]                       s_axis_tlast,
  output logic [N_PORTS-1:0]                       s_axis_tready,
  output logic                                     m_axis_tvalid,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]            m_axis_tdata,
  output logic [N_SYMBOLS-1:0]                     m_axis_tkeep,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic [N_PORTS-1:0]                       o_grant,
  output logic                                     o_busy,
  output logic [N_PORTS-1:0][W_FCNT-1:0]           o_frame_cnt
);

  localparam int W_IDX = $clog2(N_PORTS);

  arb_state_e         state_reg, state_next;
  logic [W_IDX-1:0]   idx_reg, idx_next;
  logic [W_IDX-1:0]   ptr_reg, ptr_next;
  logic [N_PORTS-1:0] grant_reg, grant_next;

  logic [N_PORTS-1:0] eligible;
  logic [N_PORTS-1:0] arb_mask;
  logic [N_PORTS-1:0] arb_req;
  logic [W_IDX-1:0]   arb_ptr;
  logic [W_IDX-1:0]   arb_win;
  logic               arb_found;

  logic               skid_in_valid;
  logic               skid_in_ready;
  axis_beat_t         skid_in_beat;
  axis_beat_t         skid_out_beat;
  logic               beat_fire;
  logic               frame_end;

  assign eligible = s_axis_tvalid & i_port_en;

  // Single arbiter shared by IDLE and frame end. At frame end the search
  // starts after the owner, and the owner is masked out: its tvalid in that
  // cycle belongs to the tlast beat being consumed, not to a new frame.
  always_comb begin
    arb_ptr  = ptr_reg;
    arb_mask = '1;
    if (state_reg == ARB_BUSY) begin
      arb_ptr  = (int'(idx_reg) == N_PORTS - 1) ? '0 : idx_reg + 1'b1;
      arb_mask = ~grant_reg;
    end
  end

  assign arb_req = eligible & arb_mask;

  always_comb begin : p_rr_search
    int               j;
    logic [W_IDX-1:0] cand;
    arb_found = 1'b0;
    arb_win   = '0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(arb_ptr) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      cand = W_IDX'(j);
      if (!arb_found && arb_req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  // Datapath: only the owner's stream reaches the skid stage.
  assign skid_in_valid     = (state_reg == ARB_BUSY) & s_axis_tvalid[idx_reg];
  assign skid_in_beat.data = s_axis_tdata[idx_reg];
  assign skid_in_beat.keep = s_axis_tkeep[idx_reg];
  assign skid_in_beat.last = s_axis_tlast[idx_reg];
  assign beat_fire         = skid_in_valid & skid_in_ready;
  assign frame_end         = beat_fire & s_axis_tlast[idx_reg];

  // tready is decoded from flops only (state, grant, skid-empty flag).
  assign s_axis_tready = (state_reg == ARB_BUSY && skid_in_ready) ? grant_reg : '0;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (arb_found) begin
          state_next = ARB_BUSY;
          idx_next   = arb_win;
          grant_next = N_PORTS'(1) << arb_win;
        end
      end
      ARB_BUSY: begin
        if (frame_end) begin
          ptr_next = arb_ptr;
          if (arb_found) begin
            idx_next   = arb_win;
            grant_next = N_PORTS'(1) << arb_win;
          end else begin
            state_next = ARB_IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
    if (!i_tx_reset_n) begin
      state_reg <= ARB_IDLE;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cnt
    logic [W_FCNT-1:0] cnt_reg;
    always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
      if (!i_tx_reset_n) begin
        cnt_reg <= '0;
      end else if (frame_end && idx_reg == W_IDX'(gi)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign o_frame_cnt[gi] = cnt_reg;
  end

  axis_skid_buffer #(
    .T (axis_beat_t)
  ) u_skid (
    .clk       (i_tx_clk),
    .rst_n     (i_tx_reset_n),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_beat   (skid_in_beat),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_beat  (skid_out_beat)
  );

  assign m_axis_tdata = skid_out_beat.data;
  assign m_axis_tkeep = skid_out_beat.keep;
  assign m_axis_tlast = skid_out_beat.last;
  assign o_grant      = grant_reg;
  assign o_busy       = (state_reg == ARB_BUSY);

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Bench for tx_axis_frame_arbiter: directed frames per port, expected beats
// queued in hand-determined arbitration order, monitor compares m_axis beats.
module tb_tx_axis_frame_arbiter;
  import mac_params::*;

  localparam int NP    = 4;
  localparam int WF    = 16;
  localparam int WD    = N_SYMBOLS * W_SYMBOL;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0] port_en;

  logic                 tv [NP];
  logic [WD-1:0]        td [NP];
  logic [N_SYMBOLS-1:0] tk [NP];
  logic                 tl [NP];

  logic [NP-1:0]                s_tvalid;
  logic [NP-1:0][WD-1:0]        s_tdata;
  logic [NP-1:0][N_SYMBOLS-1:0] s_tkeep;
  logic [NP-1:0]                s_tlast;
  logic [NP-1:0]                s_tready;

  logic                 m_valid;
  logic [WD-1:0]        m_data;
  logic [N_SYMBOLS-1:0] m_keep;
  logic                 m_last;
  logic                 m_ready;
  logic [NP-1:0]        grant;
  logic                 busy;
  logic [NP-1:0][WF-1:0] frame_cnt;

  int m_mode = 0;  // 0: ready high, 1: random with comb-path probe, 2: ready low
  int pass_cnt = 0;
  int total_cnt = 0;
  axis_beat_t exp_q[$];

  for (genvar gi = 0; gi < NP; gi++) begin : g_drv
    assign s_tvalid[gi] = tv[gi];
    assign s_tdata[gi]  = td[gi];
    assign s_tkeep[gi]  = tk[gi];
    assign s_tlast[gi]  = tl[gi];
  end

  tx_axis_frame_arbiter #(.N_PORTS(NP), .W_FCNT(WF)) dut (
    .i_tx_clk      (clk),
    .i_tx_reset_n  (rst_n),
    .i_port_en     (port_en),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [WD-1:0] bd(input int p, input int f, input int b);
    logic [WD-1:0] base;
    base = 64'hA5A5_0000_0000_0000;
    return base | WD'(p << 16) | WD'(f << 8) | WD'(b);
  endfunction

  // Last beat is partial; beat 4 (only in 8-beat frames) is an empty beat.
  function automatic logic [N_SYMBOLS-1:0] bk(input int b, input int nb);
    if (b == nb - 1) return 8'h0F;
    if (b == 4) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic push_frame(input int p, input int f, input int nb);
    axis_beat_t e;
    for (int b = 0; b < nb; b++) begin
      e.data = bd(p, f, b);
      e.keep = bk(b, nb);
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last handshake.
  task automatic send_frame(input int p, input int f, input int nb,
                            input int gap_after, input int gap_len);
    int w;
    for (int b = 0; b < nb; b++) begin
      tv[p] = 1'b1;
      td[p] = bd(p, f, b);
      tk[p] = bk(b, nb);
      tl[p] = (b == nb - 1);
      w = 0;
      @(negedge clk);
      while (!s_tready[p] && w < BOUND) begin
        w++;
        @(negedge clk);
      end
      if (!s_tready[p]) begin
        check($sformatf("port%0d_ready_timeout", p), 128'(s_tready[p]), 128'(1));
        tv[p] = 1'b0;
        tl[p] = 1'b0;
        return;
      end
      tick();
      tv[p] = 1'b0;
      tl[p] = 1'b0;
      if (b == gap_after) repeat (gap_len) tick();
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  task automatic wait_grant(input logic [NP-1:0] g);
    int w;
    w = 0;
    @(negedge clk);
    while (grant !== g && w < BOUND) begin
      w++;
      @(negedge clk);
    end
    check("wait_grant", 128'(grant), 128'(g));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) tv[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // m_axis_tready driver; in random mode it also flips tready mid-cycle and
  // confirms s_axis_tready does not follow.
  initial begin
    logic [NP-1:0] sr;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (m_mode)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
      if (m_mode == 1 && rst_n === 1'b1) begin
        #2;
        sr = s_tready;
        m_ready = ~m_ready;
        #1;
        check("tready_comb_path", 128'(s_tready), 128'(sr));
        m_ready = ~m_ready;
      end
    end
  end

  // Monitor: every m_axis transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    axis_beat_t got;
    if (rst_n === 1'b1 && m_valid && m_ready) begin
      got.data = m_data;
      got.keep = m_keep;
      got.last = m_last;
      $display("beat data=%h keep=%h last=%0d grant=%b", m_data, m_keep, m_last, grant);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got %h, expected no beat", got);
      end else begin
        check("beat", 128'(got), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    port_en = '1;
    rst_n   = 1'b0;
    for (int i = 0; i < NP; i++) begin
      tv[i] = 1'b0;
      td[i] = '0;
      tk[i] = '0;
      tl[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_m_data", 128'({m_data, m_keep, m_last}), 128'(0));
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_tready", 128'(s_tready), 128'(0));
    check("rst_cnt", 128'(frame_cnt), 128'(0));
    tick();
    rst_n = 1'b1;

    // 1: single 3-beat frame on port 0, grant at t+1, data at t+2, then idle
    push_frame(0, 0, 3);
    fork
      send_frame(0, 0, 3, -1, 0);
      begin
        @(negedge clk);
        check("t1_grant_t", 128'(grant), 128'(0));
        check("t1_tready_t", 128'(s_tready), 128'(0));
        @(negedge clk);
        check("t1_grant_t1", 128'(grant), 128'(4'b0001));
        check("t1_busy_t1", 128'(busy), 128'(1));
        check("t1_tready_t1", 128'(s_tready), 128'(4'b0001));
        check("t1_mvalid_t1", 128'(m_valid), 128'(0));
        @(negedge clk);
        check("t1_mvalid_t2", 128'(m_valid), 128'(1));
      end
    join
    @(negedge clk);
    check("t1_idle_busy", 128'(busy), 128'(0));
    check("t1_idle_grant", 128'(grant), 128'(0));
    check("t1_cnt0", 128'(frame_cnt[0]), 128'(1));
    wait_drain();

    // 2: all ports, two 2-beat frames each, order 0,1,2,3,0,1,2,3, no bubble
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) push_frame(p, f, 2);
    fork
      begin send_frame(0, 0, 2, -1, 0); send_frame(0, 1, 2, -1, 0); end
      begin send_frame(1, 0, 2, -1, 0); send_frame(1, 1, 2, -1, 0); end
      begin send_frame(2, 0, 2, -1, 0); send_frame(2, 1, 2, -1, 0); end
      begin send_frame(3, 0, 2, -1, 0); send_frame(3, 1, 2, -1, 0); end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!m_valid && w < BOUND) begin
          w++;
          @(negedge clk);
        end
        check("t2_first_grant", 128'(grant), 128'(4'b0001));
        repeat (15) begin
          @(negedge clk);
          check("t2_continuous", 128'(m_valid), 128'(1));
        end
        @(negedge clk);
        check("t2_end_valid", 128'(m_valid), 128'(0));
      end
    join
    check("t2_counts", 128'(frame_cnt), 128'({16'd2, 16'd2, 16'd2, 16'd2}));
    wait_drain();

    // 3: random backpressure, port 2 sends beats 0..7 including an empty beat
    do_reset();
    push_frame(2, 0, 8);
    m_mode = 1;
    send_frame(2, 0, 8, -1, 0);
    wait_drain();
    m_mode = 0;
    tick();

    // 4: port 2 disabled; port 1 disable mid-frame still completes first
    do_reset();
    port_en = 4'b1011;
    tv[2] = 1'b1;
    td[2] = bd(2, 0, 0);
    tk[2] = 8'hFF;
    tl[2] = 1'b1;
    push_frame(0, 0, 3);
    push_frame(1, 0, 3);
    push_frame(3, 0, 3);
    fork
      send_frame(0, 0, 3, -1, 0);
      send_frame(1, 0, 3, -1, 0);
      send_frame(3, 0, 3, -1, 0);
      begin
        wait_grant(4'b0010);
        tick();
        port_en = 4'b1001;
      end
      begin
        int g2;
        g2 = 0;
        repeat (30) begin
          @(negedge clk);
          if (grant[2]) g2++;
        end
        check("t4_port2_never", 128'(g2), 128'(0));
      end
    join
    tv[2] = 1'b0;
    tl[2] = 1'b0;
    port_en = '1;
    wait_drain();

    // 5: port 3 pauses 5 cycles mid-frame while port 0 requests
    do_reset();
    push_frame(3, 0, 4);
    push_frame(0, 0, 2);
    fork
      send_frame(3, 0, 4, 1, 5);
      begin
        wait_grant(4'b1000);
        tick();
        tick();
        fork
          send_frame(0, 0, 2, -1, 0);
          repeat (4) begin
            @(negedge clk);
            check("t5_gap_grant", 128'(grant), 128'(4'b1000));
          end
        join
      end
    join
    wait_drain();

    // 6: reset mid-frame, then ptr restarts at 0
    do_reset();
    push_frame(0, 0, 1);
    push_frame(1, 0, 1);
    fork
      send_frame(0, 0, 1, -1, 0);
      send_frame(1, 0, 1, -1, 0);
    join
    wait_drain();
    m_mode = 2;
    tick();
    tick();
    tv[2] = 1'b1;
    td[2] = bd(2, 0, 0);
    tk[2] = 8'hFF;
    tl[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_pre_mvalid", 128'(m_valid), 128'(1));
    check("t6_skid_full", 128'(s_tready), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mvalid", 128'(m_valid), 128'(0));
    check("t6_rst_grant", 128'(grant), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_tready", 128'(s_tready), 128'(0));
    check("t6_rst_cnt", 128'(frame_cnt), 128'(0));
    tv[2] = 1'b0;
    m_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(1, 1, 1);
    push_frame(3, 1, 1);
    fork
      send_frame(1, 1, 1, -1, 0);
      send_frame(3, 1, 1, -1, 0);
    join
    wait_drain();
    check("t6_counts", 128'(frame_cnt), 128'({16'd1, 16'd0, 16'd1, 16'd0}));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tx_axis_frame_arbiter.md
Name: tx_axis_frame_arbiter

Overview:
- Shares the MAC TX AXI-Stream slave input (s_axis_* of the MAC+PCS top) between N_PORTS independent frame sources.
- Grants whole frames using round-robin arbitration and a per-port enable mask.
- Registers the output through a full-throughput skid stage, so the MAC sees registered tvalid/tdata.
- Sits in the TX clock domain directly upstream of the MAC.

Parameters:
- N_PORTS, 4: number of requesters; must be at least 2.
- W_FCNT, 16: width of each per-port frame counter.
- N_SYMBOLS, W_SYMBOL: not local parameters; imported from mac_params (lanes per beat, bits per lane).

Ports:
- i_tx_clk  in  1  TX clock.
- i_tx_reset_n  in  1  asynchronous, active-low reset.
- i_port_en  in  N_PORTS  per-port enable; sampled only at arbitration.
- s_axis_tvalid  in  N_PORTS  per-port valid.
- s_axis_tdata  in  N_PORTS x N_SYMBOLS x W_SYMBOL  per-port data.
- s_axis_tkeep  in  N_PORTS x N_SYMBOLS  per-port keep.
- s_axis_tlast  in  N_PORTS  per-port last.
- s_axis_tready  out  N_PORTS  per-port ready; at most one bit is high.
- m_axis_tvalid  out  1  to MAC s_axis_tvalid.
- m_axis_tdata  out  N_SYMBOLS x W_SYMBOL  to MAC.
- m_axis_tkeep  out  N_SYMBOLS  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tready  in  1  from MAC s_axis_tready.
- o_grant  out  N_PORTS  one-hot current owner; zero when idle.
- o_busy  out  1  a frame is currently granted.
- o_frame_cnt  out  N_PORTS x W_FCNT  frames forwarded per port; wraps.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - all outputs 0;
  - state IDLE;
  - round-robin pointer ptr = 0;
  - skid stage empty;
  - counters 0.
- Eligible port: s_axis_tvalid[i] & i_port_en[i]. The winner is the first eligible index at or after ptr, searching modulo N_PORTS.
- FSM states: IDLE and BUSY(g).
- IDLE:
  - s_axis_tready = 0.
  - If any port is eligible, the next state is BUSY(winner) and o_grant/o_busy are registered.
  - A request at cycle t gives a grant at t+1. The earliest beat is accepted at t+1 and appears on m_axis at t+2.
- BUSY(g):
  - s_axis_tready[g] = skid input ready; all other tready bits are 0.
  - A beat transfers on tvalid[g] & tready[g].
  - A tvalid gap mid-frame keeps the grant.
  - Clearing i_port_en[g] mid-frame does not abort the frame.
- Frame end: on acceptance of a beat with tlast[g]:
  - o_frame_cnt[g] increments (wraps to 0 at 2^W_FCNT);
  - ptr = (g+1) mod N_PORTS;
  - in the same cycle, arbitration runs with the new ptr. If a port is eligible, the next state is BUSY(new winner) with no idle bubble; otherwise the next state is IDLE.
  - Port g itself can win again only if no other port is eligible.
- Throughput: back-to-back frames from different ports run at 1 beat/cycle while m_axis_tready = 1.
- Skid stage: two entries (main + skid).
  - Input ready = skid entry empty. This ready is a registered signal, with no combinational path from m_axis_tready to s_axis_tready.
  - Output comes from the main register.
  - No beat may be lost or duplicated under any tready pattern.
  - Beat order is preserved.
- Passthrough: tdata, tkeep and tlast pass unchanged, including tkeep = 0 beats.
- Simultaneous events:
  - The tlast acceptance and a new request in the same cycle are handled by the frame-end rule.
  - An m_axis_tready drop in the same cycle as the skid filling holds the data.
- Mid-operation reset: the frame in flight is discarded and m_axis_tvalid drops immediately. The MAC is responsible for aborting its partial frame.
- Frame-boundary guarantee: the arbiter never interleaves beats of two frames on m_axis.

Decomposition:
- Package mac_params holds N_SYMBOLS and W_SYMBOL (already present).
- Add to mac_params: typedef axis_beat_t, a packed struct with fields data, keep, last.
- Sub-module axis_skid_buffer: a two-entry register slice parameterised on the beat type, reusable on the RX path.
- The arbiter FSM, round-robin priority logic and counters stay in tx_axis_frame_arbiter.

Test Plan:
1. Single port: port 0 sends a 3-beat frame with data 0x11.., 0x22.., 0x33.., tlast on beat 3, m_axis_tready = 1 → beats appear on m_axis 2 cycles after the request; o_grant = 0001; o_frame_cnt[0] = 1; then IDLE.
2. All 4 ports request continuously with 2-beat frames → grant order 0,1,2,3,0; no idle cycle between frames; m_axis_tvalid stays high for 16 beats.
3. m_axis_tready random at 50% while port 2 sends 8 beats numbered 0..7 → m_axis carries exactly 0..7 in order; s_axis_tready never depends combinationally on m_axis_tready.
4. i_port_en = 1011 and all ports request → port 2 is never granted. Clearing en[1] mid-frame → port 1's frame completes before port 3 is granted.
5. tvalid gap: port 3 drops tvalid for 5 cycles mid-frame while port 0 requests → o_grant stays 1000 until port 3's tlast.
6. Assert reset mid-frame → all outputs 0 immediately. After release, port 1 requests → granted first (ptr = 0 search); counters read 0 except the new frame.
